uart_tx_buffered: RTL and testbench

- Parametrised UART transmitter with an internal transmit FIFO. Supports runtime baud select and parity modes, and 1 or 2 stop bits.
- Replaces the unbuffered transmitter in the UART system. Upstream logic can queue up to FIFO_DEPTH words without polling busy per byte.
- Drives the serial line consumed by the existing receiver and 7-segment display path.

---
 rtl/uart_defs.sv | 19 +
 rtl/uart_sync_fifo.sv | 40 ++++
 rtl/uart_tx_buffered.sv | 102 ++++++++++
 tb/tb_uart_tx_buffered.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// uart_defs: baud codes and divisor function, parity encodings and FSM states shared by the buffered UART transmitter
package uart_defs;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  localparam logic [2:0] BAUD_300    = 3'd0;
  localparam logic [2:0] BAUD_1200   = 3'd1;
  localparam logic [2:0] BAUD_4800   = 3'd2;
  localparam logic [2:0] BAUD_9600   = 3'd3;
  localparam logic [2:0] BAUD_19200  = 3'd4;
  localparam logic [2:0] BAUD_38400  = 3'd5;
  localparam logic [2:0] BAUD_57600  = 3'd6;
  localparam logic [2:0] BAUD_115200 = 3'd7;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam int unsigned BAUD_RATE [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};
  function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [2:0] code);
    return (clk_hz + 8 * BAUD_RATE[code]) / (16 * BAUD_RATE[code]);
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: show-ahead sync FIFO (clk, reset active-low; i_push/i_wdata in, i_pop in, o_rdata head valid with pop, o_full, o_empty, o_count)
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign w_push = i_push && !o_full;
  assign w_pop = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_wdata;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp <= w_pop ? r_rp + 1'b1 : r_rp;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter (clk, reset active-low; baud_select, parity_mode, Tx_EN, Tx_WR/Tx_DATA, ovf_clr in; Tx_D line, Tx_BUSY full, Tx_IDLE, fifo_count, sticky Tx_OVF out)
module uart_tx_buffered
  import uart_defs::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    baud_select,
  input  logic [1:0]                    parity_mode,
  input  logic                          Tx_EN,
  input  logic                          Tx_WR,
  input  logic [DATA_WIDTH-1:0]         Tx_DATA,
  input  logic                          ovf_clr,
  output logic                          Tx_D,
  output logic                          Tx_BUSY,
  output logic                          Tx_IDLE,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          Tx_OVF
);
  localparam int CW = $clog2(baud_div(CLK_HZ, BAUD_300));
  localparam int unsigned DIV_TAB [8] = '{
    baud_div(CLK_HZ, BAUD_300),   baud_div(CLK_HZ, BAUD_1200),
    baud_div(CLK_HZ, BAUD_4800),  baud_div(CLK_HZ, BAUD_9600),
    baud_div(CLK_HZ, BAUD_19200), baud_div(CLK_HZ, BAUD_38400),
    baud_div(CLK_HZ, BAUD_57600), baud_div(CLK_HZ, BAUD_115200)};
  state_t r_state, w_next;
  logic [2:0] r_baud;
  logic r_par_en, r_par_bit, r_tx_d, r_ovf;
  logic [DATA_WIDTH-1:0] r_shift, w_rdata;
  logic [CW-1:0] r_div_cnt;
  logic [3:0] r_tick_cnt, r_bit_cnt;
  logic w_full, w_empty, w_tick, w_bit_end, w_last_data, w_last_stop, w_pop, w_tx_d;
  uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (Tx_WR),
    .i_pop   (w_pop),
    .i_wdata (Tx_DATA),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );
  assign w_tick = r_div_cnt == CW'(DIV_TAB[r_baud] - 1);
  assign w_bit_end = w_tick && r_tick_cnt == 4'hF;
  assign w_last_data = w_bit_end && r_bit_cnt == 4'(DATA_WIDTH - 1);
  assign w_last_stop = w_bit_end && r_bit_cnt == 4'(STOP_BITS - 1);
  // a new frame starts from IDLE or directly at the end of STOP, so back-to-back frames have no idle gap
  assign w_pop = (r_state == ST_IDLE || (r_state == ST_STOP && w_last_stop)) && Tx_EN && !w_empty;
  assign w_tx_d = r_state == ST_START ? 1'b0 : r_state == ST_DATA ? r_shift[0] : r_state == ST_PARITY ? r_par_bit : 1'b1;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = w_pop ? ST_START : ST_IDLE;
      ST_START:  w_next = w_bit_end ? ST_DATA : ST_START;
      ST_DATA:   w_next = w_last_data ? (r_par_en ? ST_PARITY : ST_STOP) : ST_DATA;
      ST_PARITY: w_next = w_bit_end ? ST_STOP : ST_PARITY;
      ST_STOP:   w_next = w_pop ? ST_START : w_last_stop ? ST_IDLE : ST_STOP;
      default:   w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_tx_d <= 1'b1;
      r_ovf <= 1'b0;
      r_baud <= '0;
      r_par_en <= 1'b0;
      r_par_bit <= 1'b0;
      r_shift <= '0;
      r_div_cnt <= '0;
      r_tick_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_tx_d <= w_tx_d;
      r_ovf <= (Tx_WR && w_full) || (r_ovf && !ovf_clr);
      if (w_pop) begin
        r_baud <= baud_select;
        r_par_en <= parity_mode == PAR_EVEN || parity_mode == PAR_ODD;
        r_par_bit <= ^w_rdata ^ (parity_mode == PAR_ODD);
        r_shift <= w_rdata;
        r_div_cnt <= '0;
        r_tick_cnt <= '0;
        r_bit_cnt <= '0;
      end else if (r_state != ST_IDLE) begin
        r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
        r_tick_cnt <= r_tick_cnt + 4'(w_tick);
        r_bit_cnt <= !w_bit_end ? r_bit_cnt : w_next != r_state ? '0 : r_bit_cnt + 1'b1;
        r_shift <= w_bit_end && r_state == ST_DATA ? r_shift >> 1 : r_shift;
      end
    end
  end
  assign Tx_D = r_tx_d;
  assign Tx_BUSY = w_full;
  assign Tx_IDLE = w_empty && r_state == ST_IDLE;
  assign Tx_OVF = r_ovf;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: directed self-checking bench for the buffered UART transmitter
module tb_uart_tx_buffered;
  localparam int BIT = 432;
  logic clk = 1'b0, reset = 1'b0;
  logic [2:0] baud_select = 3'b111;
  logic [1:0] parity_mode = 2'b00;
  logic Tx_EN = 1'b1, Tx_WR = 1'b0, ovf_clr = 1'b0;
  logic [7:0] Tx_DATA = 8'h00;
  logic Tx_D, Tx_BUSY, Tx_IDLE, Tx_OVF;
  logic [2:0] fifo_count;
  logic tx_d2, busy2, idle2, ovf2;
  logic [2:0] count2;
  int cyc = 0, tests = 0, fails = 0;
  uart_tx_buffered u_dut (
    .clk(clk), .reset(reset), .baud_select(baud_select), .parity_mode(parity_mode),
    .Tx_EN(Tx_EN), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA), .ovf_clr(ovf_clr),
    .Tx_D(Tx_D), .Tx_BUSY(Tx_BUSY), .Tx_IDLE(Tx_IDLE), .fifo_count(fifo_count), .Tx_OVF(Tx_OVF)
  );
  uart_tx_buffered #(.STOP_BITS(2)) u_dut2 (
    .clk(clk), .reset(reset), .baud_select(baud_select), .parity_mode(parity_mode),
    .Tx_EN(Tx_EN), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA), .ovf_clr(ovf_clr),
    .Tx_D(tx_d2), .Tx_BUSY(busy2), .Tx_IDLE(idle2), .fifo_count(count2), .Tx_OVF(ovf2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic write_word(input logic [7:0] d, output int tw);
    @(negedge clk);
    Tx_WR = 1'b1;
    Tx_DATA = d;
    tw = cyc + 1;
    @(negedge clk);
    Tx_WR = 1'b0;
  endtask
  task automatic read_byte(input int t0, input int bitlen, output logic [7:0] b);
    for (int k = 0; k < 8; k++) begin
      wait_until(t0 + (k + 1) * bitlen + bitlen / 2);
      b[k] = Tx_D;
    end
  endtask
  task automatic pulse_reset;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if ({Tx_D, Tx_BUSY, Tx_IDLE, Tx_OVF, fifo_count} !== 7'b1010000) begin fails++; $display("FAIL reset_outputs: got %b exp 1010000", {Tx_D, Tx_BUSY, Tx_IDLE, Tx_OVF, fifo_count}); end
    reset = 1'b1;
  endtask
  task automatic test_single_frame;
    int tw, t0;
    logic [7:0] b;
    pulse_reset;
    write_word(8'h94, tw);
    tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL t1_count_after_write: got %0d exp 1", fifo_count); end
    wait_until(tw + 1);
    tests++; if (Tx_D !== 1'b1) begin fails++; $display("FAIL t1_line_high_n1: got %b exp 1", Tx_D); end
    wait_until(tw + 2);
    tests++; if (Tx_D !== 1'b0) begin fails++; $display("FAIL t1_start_low_n2: got %b exp 0", Tx_D); end
    t0 = tw + 2;
    read_byte(t0, BIT, b);
    tests++; if (b !== 8'h94) begin fails++; $display("FAIL t1_data: got %h exp 94", b); end
    wait_until(t0 + 9 * BIT + BIT / 2);
    tests++; if (Tx_D !== 1'b1) begin fails++; $display("FAIL t1_stop: got %b exp 1", Tx_D); end
    wait_until(tw + 4320);
    tests++; if (Tx_IDLE !== 1'b0) begin fails++; $display("FAIL t1_idle_early: got %b exp 0", Tx_IDLE); end
    wait_until(tw + 4321);
    tests++; if (Tx_IDLE !== 1'b1) begin fails++; $display("FAIL t1_idle_return: got %b exp 1", Tx_IDLE); end
  endtask
  task automatic test_parity(input logic [1:0] mode, input logic exp_par);
    int tw, t0;
    logic [7:0] b;
    pulse_reset;
    parity_mode = mode;
    write_word(8'hA1, tw);
    t0 = tw + 2;
    wait_until(t0);
    tests++; if (Tx_D !== 1'b0) begin fails++; $display("FAIL par%0d_start: got %b exp 0", mode, Tx_D); end
    read_byte(t0, BIT, b);
    tests++; if (b !== 8'hA1) begin fails++; $display("FAIL par%0d_data: got %h exp a1", mode, b); end
    wait_until(t0 + 9 * BIT + BIT / 2);
    tests++; if (Tx_D !== exp_par) begin fails++; $display("FAIL par%0d_bit: got %b exp %b", mode, Tx_D, exp_par); end
    wait_until(t0 + 10 * BIT + BIT / 2);
    tests++; if (Tx_D !== 1'b1) begin fails++; $display("FAIL par%0d_stop: got %b exp 1", mode, Tx_D); end
    wait_until(tw + 4752);
    tests++; if (Tx_IDLE !== 1'b0) begin fails++; $display("FAIL par%0d_idle_early: got %b exp 0", mode, Tx_IDLE); end
    wait_until(tw + 4753);
    tests++; if (Tx_IDLE !== 1'b1) begin fails++; $display("FAIL par%0d_idle_return: got %b exp 1", mode, Tx_IDLE); end
    parity_mode = 2'b00;
  endtask
  task automatic test_overflow;
    logic [7:0] w [6];
    logic [7:0] b;
    int c, t0;
    w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    pulse_reset;
    c = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) c = cyc;
      if (i == 5) begin
        tests++; if (Tx_BUSY !== 1'b1) begin fails++; $display("FAIL ovf_busy_at_sixth: got %b exp 1", Tx_BUSY); end
        tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_count_peak: got %0d exp 4", fifo_count); end
      end
      Tx_WR = 1'b1;
      Tx_DATA = w[i];
    end
    @(negedge clk);
    Tx_WR = 1'b0;
    tests++; if (Tx_OVF !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b exp 1", Tx_OVF); end
    tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_count_held: got %0d exp 4", fifo_count); end
    Tx_WR = 1'b1;
    Tx_DATA = 8'h77;
    ovf_clr = 1'b1;
    @(negedge clk);
    Tx_WR = 1'b0;
    ovf_clr = 1'b0;
    tests++; if (Tx_OVF !== 1'b1) begin fails++; $display("FAIL ovf_set_beats_clear: got %b exp 1", Tx_OVF); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    tests++; if (Tx_OVF !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b exp 0", Tx_OVF); end
    t0 = c + 3;
    for (int k = 0; k < 5; k++) begin
      read_byte(t0 + k * 4320, BIT, b);
      tests++; if (b !== w[k]) begin fails++; $display("FAIL ovf_frame%0d: got %h exp %h", k, b, w[k]); end
    end
    wait_until(t0 + 5 * 4320 + BIT);
    tests++; if ({Tx_IDLE, Tx_D, fifo_count} !== 5'b11000) begin fails++; $display("FAIL ovf_drained: got %b exp 11000", {Tx_IDLE, Tx_D, fifo_count}); end
  endtask
  task automatic test_back_to_back;
    int tw, tw2, t0;
    logic [7:0] b;
    pulse_reset;
    write_word(8'h5A, tw);
    write_word(8'hC3, tw2);
    t0 = tw + 2;
    read_byte(t0, BIT, b);
    tests++; if (b !== 8'h5A) begin fails++; $display("FAIL b2b_first: got %h exp 5a", b); end
    wait_until(t0 + 9 * BIT - 1);
    tests++; if (tx_d2 !== 1'b0) begin fails++; $display("FAIL b2b_sb2_last_data: got %b exp 0", tx_d2); end
    wait_until(t0 + 9 * BIT);
    tests++; if (tx_d2 !== 1'b1) begin fails++; $display("FAIL b2b_sb2_stop_begin: got %b exp 1", tx_d2); end
    wait_until(t0 + 10 * BIT - 1);
    tests++; if (Tx_D !== 1'b1) begin fails++; $display("FAIL b2b_stop_end: got %b exp 1", Tx_D); end
    wait_until(t0 + 10 * BIT);
    tests++; if (Tx_D !== 1'b0) begin fails++; $display("FAIL b2b_no_gap: got %b exp 0", Tx_D); end
    wait_until(t0 + 11 * BIT - 1);
    tests++; if (tx_d2 !== 1'b1) begin fails++; $display("FAIL b2b_sb2_stop_end: got %b exp 1", tx_d2); end
    wait_until(t0 + 11 * BIT);
    tests++; if (tx_d2 !== 1'b0) begin fails++; $display("FAIL b2b_sb2_next_start: got %b exp 0", tx_d2); end
    read_byte(t0 + 10 * BIT, BIT, b);
    tests++; if (b !== 8'hC3) begin fails++; $display("FAIL b2b_second: got %h exp c3", b); end
  endtask
  task automatic test_enable;
    int tw, tw2, t0, c;
    logic [7:0] b;
    pulse_reset;
    write_word(8'h0F, tw);
    write_word(8'hF0, tw2);
    t0 = tw + 2;
    read_byte(t0, BIT, b);
    tests++; if (b !== 8'h0F) begin fails++; $display("FAIL en_first: got %h exp 0f", b); end
    wait_until(t0 + 8 * BIT + 300);
    Tx_EN = 1'b0;
    wait_until(t0 + 10 * BIT + 500);
    tests++; if ({Tx_D, Tx_IDLE, fifo_count} !== 5'b10001) begin fails++; $display("FAIL en_hold: got %b exp 10001", {Tx_D, Tx_IDLE, fifo_count}); end
    c = cyc;
    Tx_EN = 1'b1;
    wait_until(c + 1);
    tests++; if (Tx_D !== 1'b1) begin fails++; $display("FAIL en_resume_n1: got %b exp 1", Tx_D); end
    wait_until(c + 2);
    tests++; if (Tx_D !== 1'b0) begin fails++; $display("FAIL en_resume_start: got %b exp 0", Tx_D); end
    read_byte(c + 2, BIT, b);
    tests++; if (b !== 8'hF0) begin fails++; $display("FAIL en_second: got %h exp f0", b); end
  endtask
  task automatic test_reset_mid_frame;
    int tw0, tw;
    pulse_reset;
    write_word(8'h00, tw0);
    for (int i = 0; i < 5; i++) write_word(8'h10 + 8'(i), tw);
    wait_until(tw0 + 2 + 3 * BIT);
    tests++; if ({Tx_D, Tx_BUSY, Tx_OVF} !== 3'b011) begin fails++; $display("FAIL rst_pre_state: got %b exp 011", {Tx_D, Tx_BUSY, Tx_OVF}); end
    reset = 1'b0;
    @(negedge clk);
    tests++; if ({Tx_D, Tx_BUSY, Tx_IDLE, Tx_OVF, fifo_count} !== 7'b1010000) begin fails++; $display("FAIL rst_mid_frame: got %b exp 1010000", {Tx_D, Tx_BUSY, Tx_IDLE, Tx_OVF, fifo_count}); end
    reset = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    tests++; if ({Tx_D, Tx_IDLE} !== 2'b11) begin fails++; $display("FAIL rst_stays_idle: got %b exp 11", {Tx_D, Tx_IDLE}); end
  endtask
  task automatic test_baud_change;
    int tw, tw2, t0, t1;
    pulse_reset;
    write_word(8'h01, tw);
    write_word(8'h01, tw2);
    t0 = tw + 2;
    wait_until(t0 + 100);
    baud_select = 3'b110;
    wait_until(t0 + 2 * BIT - 1);
    tests++; if (Tx_D !== 1'b1) begin fails++; $display("FAIL baud_old_bit0: got %b exp 1", Tx_D); end
    wait_until(t0 + 2 * BIT);
    tests++; if (Tx_D !== 1'b0) begin fails++; $display("FAIL baud_old_bit1: got %b exp 0", Tx_D); end
    t1 = t0 + 10 * BIT;
    wait_until(t1 - 1);
    tests++; if (Tx_D !== 1'b1) begin fails++; $display("FAIL baud_stop: got %b exp 1", Tx_D); end
    wait_until(t1);
    tests++; if (Tx_D !== 1'b0) begin fails++; $display("FAIL baud_next_start: got %b exp 0", Tx_D); end
    wait_until(t1 + 863);
    tests++; if (Tx_D !== 1'b0) begin fails++; $display("FAIL baud_new_start_len: got %b exp 0", Tx_D); end
    wait_until(t1 + 864);
    tests++; if (Tx_D !== 1'b1) begin fails++; $display("FAIL baud_new_bit0: got %b exp 1", Tx_D); end
    baud_select = 3'b111;
    pulse_reset;
  endtask
  initial begin
    test_reset;
    test_single_frame;
    test_parity(2'b01, 1'b1);
    test_parity(2'b10, 1'b0);
    test_overflow;
    test_back_to_back;
    test_enable;
    test_reset_mid_frame;
    test_baud_change;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
